lcd_cmd_driver: RTL
===================

Name: lcd_cmd_driver

Overview:
- Peripheral-side consumer of the LCD register image written by the core's store path.
- Turns each CPU write into a correctly timed HD44780-style bus transaction (RS/data setup, EN pulse, hold, execution wait).
- Reports busy/ready back to the I/O block, so software polls instead of bit-banging EN.
- Sits between the I/O register bank and the LCD pins on the board.

Parameters:
- T_SETUP_CYC, 2, cycles RS/DATA are stable before EN rises (min 1)
- T_EN_CYC, 12, cycles EN held high (min 1)
- T_HOLD_CYC, 2, cycles RS/DATA held after EN falls (min 1)
- T_EXEC_CYC, 2000, post-transaction wait for normal commands/data (min 1)
- T_CLEAR_CYC, 82000, post-transaction wait for clear (0x01) and home (0x02/0x03) commands
- T_PWRUP_CYC, 750000, power-up wait before init sequence (used only with LCD_INIT_EN)
- CNT_W, 20, counter width; must hold max(all T_*_CYC)

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  synchronous, active-high reset
- i_lcd_we  input  1  one-cycle write strobe for the LCD register
- i_lcd_wdata  input  32  register image: [31]=ON, [9]=RS, [7:0]=DATA; [10],[8] ignored
- o_ready  output  1  high when a write will be accepted this cycle
- o_drop  output  1  one-cycle pulse when a write arrives while not ready
- o_lcd_on  output  1  LCD power/backlight enable
- o_lcd_en  output  1  LCD enable strobe
- o_lcd_rs  output  1  register select (0=command, 1=data)
- o_lcd_rw  output  1  read/write; tied 0 (write-only driver)
- o_lcd_data  output  8  LCD data bus

Behaviour:
- Clock: single clock i_clk. Reset: synchronous, active-high i_reset.
- Reset values: o_lcd_en=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_data=0, o_lcd_on=0, o_drop=0, counter=0.
  - o_ready=1 after reset without LCD_INIT_EN; 0 with it.
- All outputs are registered.
- FSM states: IDLE, SETUP, PULSE, HOLD, EXEC (plus PWRUP and INIT_* with LCD_INIT_EN).
- Accept: i_lcd_we && o_ready at edge k.
  - Captures ON, RS, DATA into output regs at edge k.
  - o_lcd_on updates immediately.
  - o_ready=0 from the cycle after edge k.
  - State becomes SETUP; counter loads T_SETUP_CYC-1.
- SETUP: counter reaches 0 -> PULSE, o_lcd_en=1, counter=T_EN_CYC-1.
- PULSE: counter reaches 0 -> HOLD, o_lcd_en=0, counter=T_HOLD_CYC-1.
- HOLD: counter reaches 0 -> EXEC.
  - Counter = T_CLEAR_CYC-1 if RS=0 and DATA in {0x01,0x02,0x03}; else T_EXEC_CYC-1.
- EXEC: counter reaches 0 -> IDLE, o_ready=1.
- Timing totals:
  - o_lcd_en high for exactly T_EN_CYC cycles.
  - o_ready low for exactly T_SETUP_CYC+T_EN_CYC+T_HOLD_CYC+wait cycles.
- RS/DATA stable from acceptance through end of HOLD. Data remains on the bus in IDLE; it is not zeroed.
- Write while o_ready=0:
  - Ignored; o_drop pulses one cycle; in-flight transaction unaffected.
  - o_lcd_on is NOT updated by a dropped write.
- Write in the cycle o_ready rises (o_ready already 1): accepted normally; back-to-back transactions have no idle gap.
- Counter never wraps: each state loads and decrements only until 0.
- Reset mid-transaction: next edge forces reset values (EN drops immediately); FSM restarts at IDLE (or PWRUP).

Optional Feature:
- Macro: LCD_INIT_EN
- Defined:
  - After reset, FSM enters PWRUP for T_PWRUP_CYC cycles.
  - Then issues commands 0x38, 0x0C, 0x01, 0x06 (RS=0) through the same SETUP/PULSE/HOLD/EXEC timing. 0x01 uses T_CLEAR_CYC.
  - o_lcd_on=1 during init. o_ready stays 0 until the last EXEC completes.
  - CPU writes during init are dropped with an o_drop pulse.
- Undefined: no PWRUP/INIT states; o_ready=1 the cycle after reset deasserts; software performs init.

Test Plan (sim params T_SETUP=2, T_EN=4, T_HOLD=2, T_EXEC=10, T_CLEAR=30, T_PWRUP=20):
- Data write: i_lcd_wdata=0x8000_0241 strobe -> o_lcd_on=1, rs=1, data=0x41; EN rises 2 cycles after accept, high 4 cycles; o_ready low 18 cycles.
- Clear command: wdata=0x8000_0001 -> rs=0, data=0x01; o_ready low 2+4+2+30=38 cycles; wdata=0x8000_0002 also gives 38.
- Busy write: second strobe (0x0000_0255) 5 cycles after first -> o_drop one-cycle pulse; o_lcd_on, data, rs unchanged; first transaction timing intact.
- Back-to-back: strobe again in first cycle o_ready=1 -> accepted, new SETUP begins next cycle, no o_drop.
- Reset mid-PULSE: assert i_reset while o_lcd_en=1 -> next edge EN=0, data=0, on=0, o_ready=1 (no LCD_INIT_EN).
- LCD_INIT_EN: after reset, 20 idle cycles, then four EN pulses with data 0x38, 0x0C, 0x01, 0x06 in order; o_ready rises only after the final EXEC (10 cycles after last HOLD); writes during init pulse o_drop.

Source files
------------

// File: rtl/lcd_cmd_driver.sv
// HD44780-style command driver: turns a single register write into a timed RS/DATA/EN bus cycle.
// Optional LCD_INIT_EN adds a power-up wait and the 0x38/0x0C/0x01/0x06 init sequence after reset.
module lcd_cmd_driver #(
    parameter int T_SETUP_CYC = 2,
    parameter int T_EN_CYC    = 12,
    parameter int T_HOLD_CYC  = 2,
    parameter int T_EXEC_CYC  = 2000,
    parameter int T_CLEAR_CYC = 82000,
    parameter int T_PWRUP_CYC = 750000,
    parameter int CNT_W       = 20
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_lcd_we,
    input  logic [31:0] i_lcd_wdata,
    output logic        o_ready,
    output logic        o_drop,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data
);

    // state | meaning
    // IDLE  | bus parked, o_ready high, waiting for a write
    // SETUP | RS/DATA driven, EN low
    // PULSE | EN high
    // HOLD  | EN low again, RS/DATA still held
    // EXEC  | waiting for the LCD controller to finish the command
    // PWRUP | (LCD_INIT_EN) power-up wait before the init sequence
`ifdef LCD_INIT_EN
    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_EXEC, ST_PWRUP} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_EXEC} state_t;
`endif

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(T_EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(T_EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(T_CLEAR_CYC - 1);
    localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(T_PWRUP_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             on_q, on_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             en_q, en_d;
    logic             ready_q, ready_d;
    logic             drop_q, drop_d;
    logic             cnt_zero;
    logic             is_clear;
`ifdef LCD_INIT_EN
    logic             init_q, init_d;
    logic [1:0]       idx_q, idx_d;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction
`endif

    logic unused_wdata;
    assign unused_wdata = ^{i_lcd_wdata[30:10], i_lcd_wdata[8], PWRUP_LD};

    assign cnt_zero = (cnt_q == '0);
    // Clear and home need the long execution wait.
    assign is_clear = !rs_q && (data_q inside {8'h01, 8'h02, 8'h03});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        on_d    = on_q;
        rs_d    = rs_q;
        data_d  = data_q;
        en_d    = en_q;
        ready_d = ready_q;
        drop_d  = i_lcd_we && !ready_q;
`ifdef LCD_INIT_EN
        init_d  = init_q;
        idx_d   = idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_lcd_we && ready_q) begin
                    on_d    = i_lcd_wdata[31];
                    rs_d    = i_lcd_wdata[9];
                    data_d  = i_lcd_wdata[7:0];
                    ready_d = 1'b0;
                    cnt_d   = SETUP_LD;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    en_d    = 1'b1;
                    cnt_d   = EN_LD;
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_zero) begin
                    en_d    = 1'b0;
                    cnt_d   = HOLD_LD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    cnt_d   = is_clear ? CLEAR_LD : EXEC_LD;
                    state_d = ST_EXEC;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_EXEC: begin
                if (cnt_zero) begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
`ifdef LCD_INIT_EN
                    if (init_q && (idx_q != 2'd3)) begin
                        idx_d   = idx_q + 2'd1;
                        data_d  = init_cmd(idx_q + 2'd1);
                        ready_d = 1'b0;
                        cnt_d   = SETUP_LD;
                        state_d = ST_SETUP;
                    end else begin
                        init_d = 1'b0;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef LCD_INIT_EN
            ST_PWRUP: begin
                if (cnt_zero) begin
                    on_d    = 1'b1;
                    rs_d    = 1'b0;
                    data_d  = init_cmd(2'd0);
                    idx_d   = 2'd0;
                    cnt_d   = SETUP_LD;
                    state_d = ST_SETUP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            on_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
            drop_q  <= 1'b0;
`ifdef LCD_INIT_EN
            // Power-up wait is preloaded so PWRUP lasts exactly T_PWRUP_CYC cycles.
            state_q <= ST_PWRUP;
            cnt_q   <= PWRUP_LD;
            ready_q <= 1'b0;
            init_q  <= 1'b1;
            idx_q   <= 2'd0;
`else
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            on_q    <= on_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            drop_q  <= drop_d;
`ifdef LCD_INIT_EN
            init_q  <= init_d;
            idx_q   <= idx_d;
`endif
        end
    end

    assign o_ready    = ready_q;
    assign o_drop     = drop_q;
    assign o_lcd_on   = on_q;
    assign o_lcd_en   = en_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_data = data_q;

endmodule
